// File: rtl/fp_stream_pkg.sv
// rtl/fp_stream_pkg.sv - shared binary64 field constants, class struct and classifier
// Purpose: field layout of an IEEE-754 binary64 word, the {nan, inf, zero}
//          classification struct and function, and the default sink depth.
// Ports:   none (package).
package fp_stream_pkg;

    localparam int          EXP_LSB       = 52;
    localparam int          EXP_W         = 11;
    localparam logic [10:0] EXP_MAX       = 11'h7FF;
    localparam int          MAN_W         = 52;
    localparam int          DEFAULT_DEPTH = 8;

    typedef struct packed {
        logic nan;
        logic inf;
        logic zero;
    } fp_class_t;

    // Sign bit is ignored; denormals flag none of the three.
    function automatic fp_class_t fp_classify(input logic [63:0] d);
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] m;
        fp_class_t        c;
        e      = d[EXP_LSB +: EXP_W];
        m      = d[MAN_W-1:0];
        c.nan  = (e == EXP_MAX) && (m != '0);
        c.inf  = (e == EXP_MAX) && (m == '0);
        c.zero = (e == '0)      && (m == '0);
        return c;
    endfunction

endpackage

// File: rtl/fp_sink_fifo.sv
// rtl/fp_sink_fifo.sv - result FIFO with drop-on-full and simultaneous push/pop at full
// Purpose: stores pushed words, presents the head, tracks count/full/empty.
// Ports:   clk, rst (async active-low); push/push_data write side;
//          pop_ready read side; head_data (0 when empty); count, full, empty;
//          drop pulses when a push is discarded because the FIFO is full.
module fp_sink_fifo
    import fp_stream_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int W     = 64,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop_ready,
    output logic [W-1:0]  head_data,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          drop
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          pop;
    logic          push_acc;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign pop   = pop_ready && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_acc = push && (!full || pop);
    assign drop     = push && full && !pop;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_acc) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + AW'(1);
        end
        case ({push_acc, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: the head is masked to 0 whenever empty.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem_q[wptr_q] <= push_data;
        end
    end

    assign head_data = empty ? '0 : mem_q[rptr_q];
    assign count     = count_q;

endmodule

// File: rtl/fp_push_sink.sv
// rtl/fp_push_sink.sv - push-only FP result sink with credit counter and classification
// Purpose: buffers one-cycle pushin strobes in a FIFO, drains via valid/ready,
//          grants issue credit only when a result slot is guaranteed, and
//          classifies the head word as nan/inf/zero.
// Ports:   clk, rst (async active-low); issue in / credit_ok out;
//          pushin, din; out_valid, out_ready, out_data, out_nan/inf/zero;
//          count, inflight; sticky ovf_err and proto_err.
module fp_push_sink
    import fp_stream_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int W     = 64,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          issue,
    output logic          credit_ok,
    input  logic          pushin,
    input  logic [W-1:0]  din,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic          out_nan,
    output logic          out_inf,
    output logic          out_zero,
    output logic [CW-1:0] count,
    output logic [CW-1:0] inflight,
    output logic          ovf_err,
    output logic          proto_err
);

    localparam logic [CW:0] DEPTH_OCC = (CW+1)'(DEPTH);

    logic [CW-1:0] inflight_q, inflight_d;
    logic          ovf_q, ovf_d;
    logic          proto_q, proto_d;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_drop;
    logic [CW:0]   occupancy;
    logic [63:0]   head64;
    fp_class_t     head_class;

    fp_sink_fifo #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (pushin),
        .push_data (din),
        .pop_ready (out_ready),
        .head_data (out_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .drop      (fifo_drop)
    );

    // Stored plus outstanding results must fit in the FIFO; one extra bit
    // keeps the sum from wrapping.
    assign occupancy = {1'b0, fifo_count} + {1'b0, inflight_q};
    assign credit_ok = (occupancy < DEPTH_OCC);

    always_comb begin
        inflight_d = inflight_q;
        if (issue && !pushin) begin
            if (inflight_q != CW'(DEPTH)) begin
                inflight_d = inflight_q + CW'(1);
            end
        end else if (pushin && !issue) begin
            if (inflight_q != '0) begin
                inflight_d = inflight_q - CW'(1);
            end
        end
        ovf_d   = ovf_q | fifo_drop;
        proto_d = proto_q | (issue && !credit_ok) | (pushin && (inflight_q == '0));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_q <= '0;
            ovf_q      <= 1'b0;
            proto_q    <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            ovf_q      <= ovf_d;
            proto_q    <= proto_d;
        end
    end

    assign head64     = 64'(out_data);
    assign head_class = fp_classify(head64);

    // out_data is already 0 when empty, but the masks keep the flags
    // independent of the classifier's view of an all-zero word.
    assign out_valid = !fifo_empty;
    assign out_nan   = head_class.nan  && !fifo_empty;
    assign out_inf   = head_class.inf  && !fifo_empty;
    assign out_zero  = head_class.zero && !fifo_empty;
    assign count     = fifo_count;
    assign inflight  = inflight_q;
    assign ovf_err   = ovf_q;
    assign proto_err = proto_q;

endmodule

// File: tb/tb_fp_push_sink.sv
// tb/tb_fp_push_sink.sv - self-checking bench for fp_push_sink against a queue model
module tb_fp_push_sink;

    localparam int DEPTH = 8;
    localparam int W     = 64;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          issue;
    logic          credit_ok;
    logic          pushin;
    logic [W-1:0]  din;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_nan;
    logic          out_inf;
    logic          out_zero;
    logic [CW-1:0] count;
    logic [CW-1:0] inflight;
    logic          ovf_err;
    logic          proto_err;

    int checks = 0;
    int errors = 0;

    logic [63:0] mq[$];
    int          m_infl;
    bit          m_ovf;
    bit          m_proto;

    logic [63:0] vals [DEPTH];
    logic [63:0] specials [6];

    always #5 clk = ~clk;

    fp_push_sink #(.DEPTH(DEPTH), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .issue     (issue),
        .credit_ok (credit_ok),
        .pushin    (pushin),
        .din       (din),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_nan   (out_nan),
        .out_inf   (out_inf),
        .out_zero  (out_zero),
        .count     (count),
        .inflight  (inflight),
        .ovf_err   (ovf_err),
        .proto_err (proto_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // {nan, inf, zero} from exponent/mantissa arithmetic on the word.
    function automatic logic [2:0] ref_class(input logic [63:0] d);
        longint unsigned e;
        longint unsigned m;
        e = (d >> 52) % 2048;
        m = d % (64'd1 << 52);
        return {(e == 2047) && (m != 0), (e == 2047) && (m == 0), (e == 0) && (m == 0)};
    endfunction

    task automatic model_reset();
        mq.delete();
        m_infl  = 0;
        m_ovf   = 0;
        m_proto = 0;
    endtask

    task automatic model_step(input bit i, input bit p, input logic [63:0] d, input bit r);
        bit credit;
        bit pop;
        bit full;
        credit = (mq.size() + m_infl) < DEPTH;
        pop    = (mq.size() > 0) && r;
        full   = (mq.size() == DEPTH);
        if (i && !credit)       m_proto = 1;
        if (p && m_infl == 0)   m_proto = 1;
        if (p && full && !pop)  m_ovf = 1;
        if (i && !p)            m_infl = (m_infl == DEPTH) ? DEPTH : m_infl + 1;
        else if (p && !i)       m_infl = (m_infl == 0) ? 0 : m_infl - 1;
        if (pop)                void'(mq.pop_front());
        if (p && (!full || pop)) mq.push_back(d);
    endtask

    // One clock: drive, let the edge happen, advance the model, idle inputs.
    task automatic cyc(input bit i, input bit p, input logic [63:0] d, input bit r);
        issue     = i;
        pushin    = p;
        din       = d;
        out_ready = r;
        @(posedge clk);
        model_step(i, p, d, r);
        #1;
        issue     = 1'b0;
        pushin    = 1'b0;
        din       = '0;
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    always @(negedge clk) begin
        logic [63:0] eh;
        logic [2:0]  cls;
        eh  = (mq.size() != 0) ? mq[0] : 64'd0;
        cls = (mq.size() != 0) ? ref_class(eh) : 3'b000;
        chk("cmp_out_valid", 64'(out_valid), 64'(mq.size() != 0));
        chk("cmp_out_data",  out_data, eh);
        chk("cmp_out_nan",   64'(out_nan),  64'(cls[2]));
        chk("cmp_out_inf",   64'(out_inf),  64'(cls[1]));
        chk("cmp_out_zero",  64'(out_zero), 64'(cls[0]));
        chk("cmp_count",     64'(count),    64'(mq.size()));
        chk("cmp_inflight",  64'(inflight), 64'(m_infl));
        chk("cmp_credit_ok", 64'(credit_ok), 64'((mq.size() + m_infl) < DEPTH));
        chk("cmp_ovf_err",   64'(ovf_err),   64'(m_ovf));
        chk("cmp_proto_err", 64'(proto_err), 64'(m_proto));
    end

    initial begin
        issue     = 1'b0;
        pushin    = 1'b0;
        din       = '0;
        out_ready = 1'b0;
        specials  = '{64'h7FF8000000000000, 64'hFFF0000000000000, 64'h8000000000000000,
                      64'h0000000000000001, 64'h0000000000000000, 64'h7FF0000000000001};
        do_reset();

        // Reset values.
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data",  out_data, 64'd0);
        chk("rst_count",     64'(count), 64'd0);
        chk("rst_inflight",  64'(inflight), 64'd0);
        chk("rst_credit_ok", 64'(credit_ok), 64'd1);
        chk("rst_flags",     64'({ovf_err, proto_err, out_nan, out_inf, out_zero}), 64'd0);

        // Issue one, push 1.0: visible one cycle after the push edge.
        cyc(1, 0, 64'd0, 0);
        cyc(0, 1, 64'h3FF0000000000000, 0);
        chk("one_out_valid", 64'(out_valid), 64'd1);
        chk("one_out_data",  out_data, 64'h3FF0000000000000);
        chk("one_class",     64'({out_nan, out_inf, out_zero}), 64'd0);
        chk("one_inflight",  64'(inflight), 64'd0);
        chk("one_count",     64'(count), 64'd1);
        cyc(0, 0, 64'd0, 1);
        chk("one_drained",   64'(out_valid), 64'd0);

        // Fill to depth via credit, then overflow with one extra push.
        do_reset();
        for (int k = 0; k < DEPTH; k++) begin
            vals[k] = 64'h4000000000000000 + 64'(k * 3 + 1);
            cyc(1, 0, 64'd0, 0);
            if (k == DEPTH - 2) chk("credit_before_last", 64'(credit_ok), 64'd1);
        end
        chk("credit_after_8", 64'(credit_ok), 64'd0);
        for (int k = 0; k < DEPTH; k++) cyc(0, 1, vals[k], 0);
        chk("full_count", 64'(count), 64'd8);
        cyc(0, 1, 64'hDEADBEEF00000000, 0);
        chk("ovf_set",    64'(ovf_err), 64'd1);
        chk("ovf_count",  64'(count), 64'd8);
        chk("ovf_head",   out_data, vals[0]);
        for (int k = 0; k < DEPTH; k++) begin
            chk("drain_order", out_data, vals[k]);
            cyc(0, 0, 64'd0, 1);
        end
        chk("drain_credit", 64'(credit_ok), 64'd1);
        chk("drain_count",  64'(count), 64'd0);

        // Full FIFO with push and pop together: no overflow, newest stored last.
        do_reset();
        for (int k = 0; k < DEPTH; k++) cyc(1, 0, 64'd0, 0);
        for (int k = 0; k < DEPTH; k++) cyc(0, 1, vals[k], 0);
        cyc(0, 1, 64'h0123456789ABCDEF, 1);
        chk("pp_no_ovf", 64'(ovf_err), 64'd0);
        chk("pp_count",  64'(count), 64'd8);
        chk("pp_head",   out_data, vals[1]);
        for (int k = 1; k < DEPTH; k++) cyc(0, 0, 64'd0, 1);
        chk("pp_last",   out_data, 64'h0123456789ABCDEF);
        cyc(0, 0, 64'd0, 1);

        // Classification.
        do_reset();
        for (int k = 0; k < 4; k++) cyc(1, 0, 64'd0, 0);
        for (int k = 0; k < 4; k++) cyc(0, 1, specials[k], 0);
        chk("cls_nan",   64'({out_nan, out_inf, out_zero}), 64'b100);
        cyc(0, 0, 64'd0, 1);
        chk("cls_inf",   64'({out_nan, out_inf, out_zero}), 64'b010);
        cyc(0, 0, 64'd0, 1);
        chk("cls_zero",  64'({out_nan, out_inf, out_zero}), 64'b001);
        cyc(0, 0, 64'd0, 1);
        chk("cls_denorm", 64'({out_nan, out_inf, out_zero}), 64'b000);
        cyc(0, 0, 64'd0, 1);

        // Protocol errors.
        do_reset();
        cyc(0, 1, 64'h1234, 0);
        chk("proto_push",      64'(proto_err), 64'd1);
        chk("proto_push_cnt",  64'(count), 64'd1);
        chk("proto_push_infl", 64'(inflight), 64'd0);
        chk("proto_push_data", out_data, 64'h1234);
        do_reset();
        for (int k = 0; k < DEPTH; k++) cyc(1, 0, 64'd0, 0);
        chk("proto_clean", 64'(proto_err), 64'd0);
        cyc(1, 0, 64'd0, 0);
        chk("proto_issue", 64'(proto_err), 64'd1);
        chk("infl_sat",    64'(inflight), 64'd8);
        do_reset();
        cyc(1, 1, 64'h55, 0);
        chk("both_infl",  64'(inflight), 64'd0);
        chk("both_proto", 64'(proto_err), 64'd1);
        chk("both_count", 64'(count), 64'd1);

        // Asynchronous reset mid-cycle with count=5, inflight=2.
        do_reset();
        for (int k = 0; k < 7; k++) cyc(1, 0, 64'd0, 0);
        for (int k = 0; k < 5; k++) cyc(0, 1, vals[k], 0);
        chk("pre_async_count", 64'(count), 64'd5);
        chk("pre_async_infl",  64'(inflight), 64'd2);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk("async_out_valid", 64'(out_valid), 64'd0);
        chk("async_out_data",  out_data, 64'd0);
        chk("async_count",     64'(count), 64'd0);
        chk("async_inflight",  64'(inflight), 64'd0);
        chk("async_credit",    64'(credit_ok), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // Randomized traffic, mostly protocol-clean, with occasional violations.
        for (int n = 0; n < 1200; n++) begin
            bit          ri;
            bit          rp;
            bit          rr;
            logic [63:0] rd;
            bit          credit_now;
            credit_now = (mq.size() + m_infl) < DEPTH;
            ri = ($urandom_range(0, 2) == 0) && (credit_now || $urandom_range(0, 19) == 0);
            rp = (m_infl > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 24) == 0);
            rr = ((n / 100) % 2 == 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 3) == 0) rd = specials[$urandom_range(0, 5)];
            else rd = {$urandom, $urandom};
            if (n == 600) do_reset();
            cyc(ri, rp, rd, rr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
